// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage
//  Description : Registered operand/issue stage in front of the integer ALU.
//                Accepts decoded OP/OP-IMM instructions over a valid/ready
//                handshake, decodes them on entry, and holds them in a
//                2-entry skid buffer (main = head, skid = overflow).
//                The head entry drives the ALU operands and the shift
//                unit's amount, direction, arithmetic-select and enable
//                inputs straight from flops. Illegal shift encodings are
//                flagged and never enable the shift unit.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK          in   1     clock, rising edge
//    rst_n        in   1     synchronous active-low reset
//    flush        in   1     synchronous flush, drops both buffered entries
//    in_valid     in   1     upstream entry valid
//    in_ready     out  1     stage can accept (registered, = !skid_valid)
//    in_rs1       in   XLEN  rs1 value
//    in_rs2       in   XLEN  rs2 value
//    in_imm       in   12    I-type immediate (instr[31:20])
//    in_is_imm    in   1     1 = OP-IMM, 0 = OP
//    in_funct3    in   3     funct3
//    in_funct7_5  in   1     instr[30] for OP format
//    out_valid    out  1     head entry valid
//    out_ready    in   1     downstream consumes head this cycle
//    Rs1          out  XLEN  operand A
//    Op_B         out  XLEN  operand B (sign-extended imm or rs2)
//    Shamt        out  5     shift amount
//    funct3_2     out  1     shift direction (0 left, 1 right)
//    funct7_5     out  1     arithmetic select
//    Shift_En     out  1     head is a legal shift
//    Illegal      out  1     head is an illegal shift encoding
// ============================================================================
module alu_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [11:0]     in_imm,
  input  logic            in_is_imm,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Rs1,
  output logic [XLEN-1:0] Op_B,
  output logic [4:0]      Shamt,
  output logic            funct3_2,
  output logic            funct7_5,
  output logic            Shift_En,
  output logic            Illegal
);

  // Upper immediate bits that distinguish SRAI from SRLI/SLLI.
  localparam logic [6:0] c_IMM_HI_ZERO = 7'b0000000;
  localparam logic [6:0] c_IMM_HI_SRA  = 7'b0100000;
  localparam logic [1:0] c_F3_SHIFT_LO = 2'b01;

  // One buffered, already-decoded entry.
  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] op_b;
    logic [4:0]      shamt;
    logic            f3_2;
    logic            f7_5;
    logic            is_shift;
    logic            illegal;
  } entry_t;

  localparam entry_t c_ENTRY_ZERO = '0;

  // --------------------------------------------------------------------------
  // Entry decode
  // --------------------------------------------------------------------------
  entry_t     w_dec;
  logic [6:0] w_imm_hi;
  logic       w_is_shift;
  logic       w_arith;
  logic       w_bad_imm_hi;
  logic       w_bad_left_arith;

  always_comb begin
    w_imm_hi   = in_imm[11:5];
    w_is_shift = (in_funct3[1:0] == c_F3_SHIFT_LO);
    // Arithmetic select comes from imm[10] for OP-IMM, instr[30] for OP.
    w_arith    = in_is_imm ? in_imm[10] : in_funct7_5;

    // OP-IMM shifts reuse imm[11:5] as funct7: only all-zero is legal,
    // except that right shifts may also carry the SRAI pattern.
    w_bad_imm_hi = in_is_imm
                   && (w_imm_hi != c_IMM_HI_ZERO)
                   && !(in_funct3[2] && (w_imm_hi == c_IMM_HI_SRA));
    // There is no arithmetic left shift in either format.
    w_bad_left_arith = !in_funct3[2] && w_arith;

    w_dec          = c_ENTRY_ZERO;
    w_dec.rs1      = in_rs1;
    w_dec.op_b     = in_is_imm ? {{(XLEN-12){in_imm[11]}}, in_imm} : in_rs2;
    w_dec.shamt    = in_is_imm ? in_imm[4:0] : in_rs2[4:0];
    w_dec.f3_2     = in_funct3[2];
    w_dec.f7_5     = w_arith;
    w_dec.is_shift = w_is_shift;
    w_dec.illegal  = w_is_shift && (w_bad_imm_hi || w_bad_left_arith);
  end

  // --------------------------------------------------------------------------
  // Skid buffer control
  // --------------------------------------------------------------------------
  entry_t r_main;
  entry_t r_skid;
  logic   r_main_valid;
  logic   r_skid_valid;
  logic   r_in_ready;

  logic   w_accept;
  logic   w_main_open;
  logic   w_load_main_from_skid;
  logic   w_load_main_from_in;
  logic   w_load_skid;
  logic   w_main_valid_nxt;
  logic   w_skid_valid_nxt;

  always_comb begin
    w_accept    = in_valid && r_in_ready;
    // Main can take a new entry when it is empty or its entry leaves now.
    w_main_open = !r_main_valid || out_ready;

    // Skid always refills main first so ordering is preserved.
    w_load_main_from_skid = !flush && w_main_open && r_skid_valid;
    w_load_main_from_in   = !flush && w_main_open && !r_skid_valid && w_accept;
    w_load_skid           = !flush && !w_main_open && w_accept;

    w_main_valid_nxt = r_main_valid;
    if (flush) begin
      w_main_valid_nxt = 1'b0;
    end else if (w_main_open) begin
      w_main_valid_nxt = r_skid_valid || w_accept;
    end

    w_skid_valid_nxt = r_skid_valid;
    if (flush) begin
      w_skid_valid_nxt = 1'b0;
    end else if (w_load_skid) begin
      w_skid_valid_nxt = 1'b1;
    end else if (w_main_open) begin
      w_skid_valid_nxt = 1'b0;
    end
  end

  // Valid flags and the registered ready. in_ready is computed from the
  // next skid state so it never depends combinationally on out_ready.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
    end
  end

  // Data slots only move on a load; contents are don't-care when invalid.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_main <= c_ENTRY_ZERO;
    end else if (w_load_main_from_skid) begin
      r_main <= r_skid;
    end else if (w_load_main_from_in) begin
      r_main <= w_dec;
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_skid <= c_ENTRY_ZERO;
    end else if (w_load_skid) begin
      r_skid <= w_dec;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all from flops; only the flags are qualified by head valid.
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = r_in_ready;
    out_valid = r_main_valid;
    Rs1       = r_main.rs1;
    Op_B      = r_main.op_b;
    Shamt     = r_main.shamt;
    funct3_2  = r_main.f3_2;
    funct7_5  = r_main.f7_5;
    Shift_En  = r_main_valid && r_main.is_shift && !r_main.illegal;
    Illegal   = r_main_valid && r_main.illegal;
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_operand_stage
//  Description : Self-checking bench for alu_operand_stage. A queue-based
//                reference model (capacity 2, FIFO order) predicts the head
//                entry, validity and ready every cycle; directed scenarios
//                add explicit expected constants for the key encodings.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_operand_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [11:0]     in_imm;
  logic            in_is_imm;
  logic [2:0]      in_funct3;
  logic            in_funct7_5;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] Rs1;
  logic [XLEN-1:0] Op_B;
  logic [4:0]      Shamt;
  logic            funct3_2;
  logic            funct7_5;
  logic            Shift_En;
  logic            Illegal;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(XLEN)) dut (
    .CLK        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .in_is_imm  (in_is_imm),
    .in_funct3  (in_funct3),
    .in_funct7_5(in_funct7_5),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Rs1        (Rs1),
    .Op_B       (Op_B),
    .Shamt      (Shamt),
    .funct3_2   (funct3_2),
    .funct7_5   (funct7_5),
    .Shift_En   (Shift_En),
    .Illegal    (Illegal)
  );

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] opb;
    logic [4:0]  shamt;
    logic        f3_2;
    logic        f7_5;
    logic        sh_en;
    logic        ill;
  } exp_t;

  exp_t q[$];
  bit   m_ready;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference decode written from the instruction-set rules with plain
  // arithmetic on integer values.
  function automatic exp_t ref_decode(input logic [31:0] rs1, input logic [31:0] rs2,
                                      input logic [11:0] imm, input bit is_imm,
                                      input int f3, input bit f75);
    exp_t e;
    int   imm_i;
    int   upper;
    bit   arith;
    bit   shift_op;
    bit   bad;
    imm_i    = int'(imm);
    upper    = imm_i / 32;
    arith    = is_imm ? bit'((imm_i / 1024) % 2) : f75;
    shift_op = (f3 == 1) || (f3 == 5);
    if (imm_i >= 2048) imm_i = imm_i - 4096;
    e.rs1   = rs1;
    e.opb   = is_imm ? 32'(imm_i) : rs2;
    e.shamt = is_imm ? 5'(int'(imm) % 32) : 5'(rs2 % 32);
    e.f3_2  = (f3 >= 4);
    e.f7_5  = arith;
    bad = 1'b0;
    if (f3 == 1)      bad = arith || (is_imm && upper != 0);
    else if (f3 == 5) bad = is_imm && upper != 0 && upper != 32;
    e.ill   = shift_op && bad;
    e.sh_en = shift_op && !bad;
    return e;
  endfunction

  task automatic check_outputs();
    check("in_ready", in_ready, m_ready);
    check("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("Rs1", Rs1, q[0].rs1);
      check("Op_B", Op_B, q[0].opb);
      check("Shamt", Shamt, q[0].shamt);
      check("funct3_2", funct3_2, q[0].f3_2);
      check("funct7_5", funct7_5, q[0].f7_5);
      check("Shift_En", Shift_En, q[0].sh_en);
      check("Illegal", Illegal, q[0].ill);
    end else begin
      check("Shift_En_idle", Shift_En, 1'b0);
      check("Illegal_idle", Illegal, 1'b0);
    end
  endtask

  // One clock: model follows the edge using the inputs held since the last
  // falling edge, then outputs are compared at the falling edge.
  task automatic cycle();
    bit acc;
    @(posedge clk);
    if (!rst_n || flush) begin
      q.delete();
      m_ready = rst_n;
    end else begin
      acc = in_valid && m_ready;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) q.push_back(ref_decode(in_rs1, in_rs2, in_imm, in_is_imm,
                                      int'(in_funct3), in_funct7_5));
      m_ready = (q.size() < 2);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic offer(input logic [31:0] rs1, input logic [31:0] rs2, input logic [11:0] imm,
                       input bit is_imm, input logic [2:0] f3, input bit f75);
    in_valid    = 1'b1;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_imm      = imm;
    in_is_imm   = is_imm;
    in_funct3   = f3;
    in_funct7_5 = f75;
  endtask

  logic [31:0] seen[$];

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_is_imm = 1'b0;
    in_funct3 = '0; in_funct7_5 = 1'b0;
    m_ready = 1'b0;

    // Reset state
    cycle();
    cycle();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_data", {Rs1, Op_B}, 64'h0);
    check("rst_flags", {Shamt, funct3_2, funct7_5, Shift_En, Illegal}, 64'h0);
    rst_n = 1'b1;
    cycle();
    check("post_rst_ready", in_ready, 1'b1);

    // SRAI
    out_ready = 1'b1;
    offer(32'h8000_0000, 32'h0, 12'h41F, 1'b1, 3'b101, 1'b0);
    cycle();
    in_valid = 1'b0;
    check("srai_valid", out_valid, 1'b1);
    check("srai_shamt", Shamt, 5'd31);
    check("srai_dir_arith", {funct3_2, funct7_5}, 2'b11);
    check("srai_en_ill", {Shift_En, Illegal}, 2'b10);
    check("srai_opb", Op_B, 32'h0000_041F);
    check("srai_rs1", Rs1, 32'h8000_0000);

    // SRL register form
    offer(32'h1234_5678, 32'hFFFF_FFE4, 12'h000, 1'b0, 3'b101, 1'b0);
    cycle();
    in_valid = 1'b0;
    check("srl_shamt", Shamt, 5'h04);
    check("srl_opb", Op_B, 32'hFFFF_FFE4);
    check("srl_en", Shift_En, 1'b1);

    // Illegal SLLI
    offer(32'h1, 32'h0, 12'h401, 1'b1, 3'b001, 1'b0);
    cycle();
    in_valid = 1'b0;
    check("slli_bad", {out_valid, Illegal, Shift_En}, 3'b110);

    // Illegal OP SLL with funct7_5
    offer(32'h2, 32'h3, 12'h000, 1'b0, 3'b001, 1'b1);
    cycle();
    in_valid = 1'b0;
    check("sll_bad", {out_valid, Illegal, Shift_En}, 3'b110);

    // ADD: no shift
    offer(32'h4, 32'h5, 12'h000, 1'b0, 3'b000, 1'b0);
    cycle();
    in_valid = 1'b0;
    check("add_flags", {out_valid, Illegal, Shift_En}, 3'b100);
    cycle();

    // Back-pressure: A, B, C with out_ready low
    out_ready = 1'b0;
    offer(32'hAAAA_0001, 32'h0, 12'h0, 1'b0, 3'b000, 1'b0);
    cycle();
    offer(32'hAAAA_0002, 32'h0, 12'h0, 1'b0, 3'b000, 1'b0);
    cycle();
    offer(32'hAAAA_0003, 32'h0, 12'h0, 1'b0, 3'b000, 1'b0);
    check("bp_ready_at_C", in_ready, 1'b0);
    check("bp_head_A", Rs1, 32'hAAAA_0001);
    cycle();
    out_ready = 1'b1;
    seen.delete();
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen.push_back(Rs1);
      if (in_valid && in_ready) begin
        cycle();
        in_valid = 1'b0;
      end else begin
        cycle();
      end
    end
    check("bp_count", seen.size(), 3);
    if (seen.size() == 3) begin
      check("bp_order0", seen[0], 32'hAAAA_0001);
      check("bp_order1", seen[1], 32'hAAAA_0002);
      check("bp_order2", seen[2], 32'hAAAA_0003);
    end

    // Flush with both slots full and a simultaneous input
    out_ready = 1'b0;
    offer(32'hB001, 32'h0, 12'h0, 1'b0, 3'b000, 1'b0);
    cycle();
    offer(32'hB002, 32'h0, 12'h0, 1'b0, 3'b000, 1'b0);
    cycle();
    check("fl_full", in_ready, 1'b0);
    offer(32'hB003, 32'h0, 12'h0, 1'b0, 3'b000, 1'b0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", out_valid, 1'b0);
    check("fl_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    cycle();
    check("fl_dropped", out_valid, 1'b0);

    // Reset mid-stream with both slots full
    out_ready = 1'b0;
    offer(32'hC001, 32'h0, 12'h0, 1'b0, 3'b000, 1'b0);
    cycle();
    offer(32'hC002, 32'h0, 12'h0, 1'b0, 3'b000, 1'b0);
    cycle();
    in_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    check("mrst_valid_ready", {out_valid, in_ready}, 2'b00);
    check("mrst_data", {Rs1, Op_B}, 64'h0);
    check("mrst_flags", {Shamt, funct3_2, funct7_5, Shift_En, Illegal}, 64'h0);
    rst_n = 1'b1;
    cycle();
    check("mrst_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    offer(32'hC0DE, 32'h0, 12'h0, 1'b0, 3'b000, 1'b0);
    cycle();
    in_valid = 1'b0;
    check("mrst_first", {out_valid, Rs1}, {1'b1, 32'hC0DE});

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid    = ($urandom_range(0, 99) < 65);
      out_ready   = ($urandom_range(0, 99) < 60);
      flush       = ($urandom_range(0, 99) < 3);
      rst_n       = ($urandom_range(0, 199) != 0);
      in_rs1      = $urandom;
      in_rs2      = $urandom;
      in_is_imm   = $urandom_range(0, 1);
      in_funct3   = 3'($urandom_range(0, 7));
      in_funct7_5 = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0:       in_imm = {7'b0000000, 5'($urandom)};
        1:       in_imm = {7'b0100000, 5'($urandom)};
        default: in_imm = 12'($urandom);
      endcase
      cycle();
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
# alu_operand_stage

Registered operand/issue stage sitting directly upstream of the integer ALU's combinational shift, add and logic units. It accepts decoded OP/OP-IMM instructions over a valid/ready handshake and buffers them in a 2-entry skid buffer. It drives the shift unit's operand, shift-amount, function-select and enable inputs from registers, so the shift datapath starts each cycle from flops. It also screens shift encodings, flagging illegal ones before they reach the unit.

## Interface
Parameters:
- XLEN, 32, datapath width; shift amount is fixed at 5 bits.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous pipeline flush; drops all buffered entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- in_rs1  in  XLEN  rs1 register value.
- in_rs2  in  XLEN  rs2 register value.
- in_imm  in  12  I-type immediate field (instr[31:20]).
- in_is_imm  in  1  1 = OP-IMM, 0 = OP.
- in_funct3  in  3  instruction funct3.
- in_funct7_5  in  1  instr[30] for OP-format instructions.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream (ALU/EX-MEM register) consumes head this cycle.
- Rs1  out  XLEN  operand A to ALU units.
- Op_B  out  XLEN  operand B: sign-extended in_imm if in_is_imm, else in_rs2.
- Shamt  out  5  shift amount to shift unit: in_imm[4:0] if in_is_imm, else in_rs2[4:0].
- funct3_2  out  1  in_funct3[2] (0 = left, 1 = right).
- funct7_5  out  1  arithmetic select: in_imm[10] if in_is_imm, else in_funct7_5.
- Shift_En  out  1  head valid AND in_funct3[1:0]==2'b01 AND not illegal.
- Illegal  out  1  head is an illegal shift encoding.

## Operation
- Decode happens on entry to the buffer. Each entry stores Rs1, Op_B, Shamt, funct3_2, funct7_5, is_shift and Illegal. Outputs always reflect the main (head) entry.
- A shift is funct3 = 001 (SLL/SLLI) or 101 (SRL/SRA/SRLI/SRAI).
- Illegal shift encodings:
  - OP-IMM shift with in_imm[11:5] not equal to 7'b0000000, and not equal to 7'b0100000 when funct3 = 101.
  - funct3 = 001 with the arithmetic bit set, in either format.
  - An illegal entry still flows with out_valid=1, Illegal=1, Shift_En=0.
- Non-shift entries: Shift_En=0, Illegal=0.
- Two storage slots: main (head) and skid.
- An accept occurs when in_valid && in_ready.
- Main update on each edge, in priority order:
  1. Flush: main_valid ← 0.
  2. Main empty, or draining (out_ready):
     - if skid_valid, main ← skid;
     - else if accept, main ← input;
     - else main_valid ← 0.
  3. Main full and !out_ready: hold.
- Skid update:
  - Accept while main full and !out_ready → skid ← input.
  - Skid moves to main when main drains; skid_valid clears.
  - A new accept cannot coincide with skid_valid=1, because in_ready=0.
- Flush has priority over everything:
  - clears main_valid and skid_valid;
  - a same-cycle input is dropped;
  - in_ready=1 on the next cycle.
- Data registers update only on load. Their values are don't-care when the slot is invalid, but Shift_En and Illegal are gated by valid.

## Timing
- Reset: out_valid=0, skid_valid=0, in_ready=0 while rst_n=0 and 1 on the first cycle after release.
- Rs1, Op_B, Shamt, funct3_2, funct7_5, Shift_En and Illegal reset to 0.
- Latency: an entry accepted at edge N appears at the outputs after edge N, with out_valid=1 in cycle N+1.
- Throughput: one entry per cycle while out_ready=1. There is no bubble on back-to-back traffic.
- Stall:
  - The first accept during stall lands in skid; in_ready drops to 0 the next cycle.
  - The second stalled producer is held upstream.
  - On out_ready, skid reaches the head one cycle later and in_ready returns to 1.
- No combinational path from out_ready to in_ready, or from any input to any output.
- Reset asserted mid-stream discards both entries exactly as flush does.

## Test plan
- SRAI: in_is_imm=1, funct3=101, in_imm=12'h41F, in_rs1=32'h8000_0000, out_ready=1 → next cycle Shamt=31, funct3_2=1, funct7_5=1, Shift_En=1, Illegal=0, Op_B=32'h0000_041F.
- SRL register form: in_rs2=32'hFFFF_FFE4 → Shamt=5'h04 and Op_B=32'hFFFF_FFE4.
- Illegal encodings:
  - SLLI with in_imm=12'h401 → out_valid=1, Illegal=1, Shift_En=0.
  - OP SLL with in_funct7_5=1 → same response.
  - ADD (funct3=000) → Shift_En=0, Illegal=0.
- Back-pressure:
  - Entries A, B, C offered on consecutive cycles with out_ready=0 → A in main, B in skid, in_ready=0 on the cycle C is offered.
  - Raise out_ready → heads appear in order A, B, C with no loss or duplication.
- Flush with both slots full, plus a simultaneous valid input → out_valid=0 next cycle, that input never appears, in_ready=1.
- Reset mid-stream: rst_n=0 for one cycle with both slots full → all outputs 0; the first post-reset entry appears with 1-cycle latency.
